// File: rtl/alu_decode_stage_pkg.sv
// Shared definitions for the MIPS32 ALU-control decode stage: opcode/funct
// encodings, ALU operation codes and the combinational instruction decoder.
package alu_defs;

    localparam int CTRL_W_MIN = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_LUI  = 4'b1100,
        ALU_MD   = 4'b1111
    } alu_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
        logic    is_md;
        logic    is_mfhilo;
    } decode_t;

    // funct is only meaningful for R-type words; I-type low bits are immediates.
    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [5:0] opcode;
        logic [5:0] funct;
        opcode      = instr[31:26];
        funct       = instr[5:0];
        d.op        = ALU_ADD;
        d.illegal   = 1'b0;
        d.is_md     = 1'b0;
        d.is_mfhilo = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SLL:                      d.op = ALU_SLL;
                F_SRL:                      d.op = ALU_SRL;
                F_SRA:                      d.op = ALU_SRA;
                F_ADD, F_ADDU, F_JR:        d.op = ALU_ADD;
                F_SUB, F_SUBU:              d.op = ALU_SUB;
                F_AND:                      d.op = ALU_AND;
                F_OR:                       d.op = ALU_OR;
                F_XOR:                      d.op = ALU_XOR;
                F_NOR:                      d.op = ALU_NOR;
                F_SLT:                      d.op = ALU_SLT;
                F_SLTU:                     d.op = ALU_SLTU;
                F_MFHI, F_MFLO:             d.is_mfhilo = 1'b1;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    d.op    = ALU_MD;
                    d.is_md = 1'b1;
                end
                default:                    d.illegal = 1'b1;
            endcase
        end else begin
            case (opcode)
                OP_BEQ, OP_BNE:                         d.op = ALU_SUB;
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW,
                OP_J, OP_JAL:                           d.op = ALU_ADD;
                OP_SLTI:                                d.op = ALU_SLT;
                OP_SLTIU:                               d.op = ALU_SLTU;
                OP_ANDI:                                d.op = ALU_AND;
                OP_ORI:                                 d.op = ALU_OR;
                OP_XORI:                                d.op = ALU_XOR;
                OP_LUI:                                 d.op = ALU_LUI;
                default:                                d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_md_sequencer.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM that holds busy for exactly
// MD_CYCLES cycles after a start request.
module alu_md_sequencer
    import alu_defs::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int MD_CNT_W  = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] LAST_COUNT = MD_CNT_W'(MD_CYCLES - 1);

    md_state_e           state_reg, state_next;
    logic [MD_CNT_W-1:0] count_reg, count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= MD_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            MD_IDLE: begin
                count_next = '0;
                if (start) begin
                    state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (count_reg == LAST_COUNT) begin
                    state_next = MD_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + MD_CNT_W'(1);
                end
            end
            default: begin
                state_next = MD_IDLE;
                count_next = '0;
            end
        endcase
    end

    assign busy = (state_reg == MD_BUSY);

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU-control decode stage with valid/ready handshake; stalls
// mult/div and mfhi/mflo words while the MD unit is occupied.
module alu_decode_stage
    import alu_defs::*;
#(
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32,
    parameter int MD_CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              md_start,
    output logic              md_busy
);

    decode_t           dec;
    logic              stall;
    logic              accept;
    logic              md_go;

    logic              out_valid_reg;
    logic [CTRL_W-1:0] alucontrol_reg;
    logic              illegal_reg;
    logic              md_start_reg;

    assign dec = decode_instr(instruct);

    // md_busy is registered, so a word arriving the cycle busy drops is accepted.
    assign stall    = md_busy && in_valid && (dec.is_md || dec.is_mfhilo);
    assign in_ready = (!out_valid_reg || out_ready) && !stall;
    assign accept   = in_valid && in_ready;
    assign md_go    = accept && dec.is_md;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            alucontrol_reg <= CTRL_W'(ALU_ADD);
            illegal_reg    <= 1'b0;
            md_start_reg   <= 1'b0;
        end else begin
            md_start_reg <= md_go;
            if (accept) begin
                out_valid_reg  <= 1'b1;
                alucontrol_reg <= CTRL_W'(dec.op);
                illegal_reg    <= dec.illegal;
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    alu_md_sequencer #(
        .MD_CYCLES (MD_CYCLES),
        .MD_CNT_W  (MD_CNT_W)
    ) u_md_sequencer (
        .clk   (clk),
        .reset (reset),
        .start (md_go),
        .busy  (md_busy)
    );

    assign out_valid  = out_valid_reg;
    assign alucontrol = alucontrol_reg;
    assign illegal    = illegal_reg;
    assign md_start   = md_start_reg;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage with MD_CYCLES=4.
module tb_alu_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruct;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alucontrol;
    logic        illegal;
    logic        md_start;
    logic        md_busy;

    int n_cmp;
    int n_bad;

    localparam logic [31:0] W_MULT = 32'h0085_0018;
    localparam logic [31:0] W_MFLO = 32'h0000_1012;
    localparam logic [31:0] W_ADD  = 32'h0085_1020;
    localparam logic [31:0] W_XOR  = 32'h0085_1026;
    localparam logic [31:0] W_OR   = 32'h0085_1025;

    alu_decode_stage #(
        .CTRL_W    (4),
        .MD_CYCLES (4),
        .MD_CNT_W  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruct   (instruct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .md_start   (md_start),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_one(input logic [31:0] w, input logic [3:0] ec,
                            input logic ei, input string nm);
        @(negedge clk);
        in_valid  = 1'b1;
        instruct  = w;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s in_ready got %b want 1", nm, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s out_valid got %b want 1", nm, out_valid);
        end
        n_cmp++;
        if (alucontrol !== ec) begin
            n_bad++; $display("FAIL %s alucontrol got %b want %b", nm, alucontrol, ec);
        end
        n_cmp++;
        if (illegal !== ei) begin
            n_bad++; $display("FAIL %s illegal got %b want %b", nm, illegal, ei);
        end
        $display("txn %-8s instr=%h alucontrol=%b illegal=%b", nm, w, alucontrol, illegal);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (alucontrol !== 4'b0010) begin n_bad++; $display("FAIL reset alucontrol got %b want 0010", alucontrol); end
        n_cmp++;
        if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset illegal got %b want 0", illegal); end
        n_cmp++;
        if (md_start !== 1'b0 || md_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset md got start=%b busy=%b want 0/0", md_start, md_busy);
        end
        $display("txn reset    out_valid=%b alucontrol=%b", out_valid, alucontrol);
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        send_one(W_ADD,        4'b0010, 1'b0, "add");
        send_one(32'h00851027, 4'b0100, 1'b0, "nor");
        send_one(32'h000510C3, 4'b1010, 1'b0, "sra");
        send_one(32'h00051080, 4'b1000, 1'b0, "sll");
        send_one(32'h00051082, 4'b1001, 1'b0, "srl");
        send_one(32'h0085102A, 4'b0111, 1'b0, "slt");
        send_one(32'h0085102B, 4'b1011, 1'b0, "sltu");
        send_one(32'h00851022, 4'b0110, 1'b0, "sub");
        send_one(W_MFLO,       4'b0010, 1'b0, "mflo_idle");
        send_one(32'h03E00008, 4'b0010, 1'b0, "jr");
    endtask

    task automatic test_itype();
        send_one(32'h2C85000A, 4'b1011, 1'b0, "sltiu");
        send_one(32'h3C011234, 4'b1100, 1'b0, "lui");
        send_one(32'h20850020, 4'b0010, 1'b0, "addi_f20");
        send_one(32'h20850022, 4'b0010, 1'b0, "addi_f22");
        send_one(32'h10850004, 4'b0110, 1'b0, "beq");
        send_one(32'h38850001, 4'b0011, 1'b0, "xori");
        send_one(32'h8C850000, 4'b0010, 1'b0, "lw");
        send_one(32'h08000000, 4'b0010, 1'b0, "j");
    endtask

    task automatic test_illegal();
        send_one(32'hFC000000, 4'b0010, 1'b1, "ill_op");
        send_one(32'h00000001, 4'b0010, 1'b1, "ill_fn");
    endtask

    task automatic test_md_stall();
        // cycle T: mult presented and accepted
        @(negedge clk);
        in_valid = 1'b1; instruct = W_MULT; out_ready = 1'b1;
        #1; n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL md_T in_ready got %b want 1", in_ready); end
        // T+1
        @(negedge clk);
        n_cmp++;
        if (md_start !== 1'b1 || md_busy !== 1'b1) begin
            n_bad++; $display("FAIL md_T1 start/busy got %b/%b want 1/1", md_start, md_busy);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || alucontrol !== 4'b1111) begin
            n_bad++; $display("FAIL md_T1 out got v=%b c=%b want 1/1111", out_valid, alucontrol);
        end
        instruct = W_MFLO;
        #1; n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL md_T1 mflo in_ready got %b want 0", in_ready); end
        $display("txn mult     accepted, md_start=%b md_busy=%b", md_start, md_busy);
        // T+2: an unrelated add flows past the busy unit
        @(negedge clk);
        n_cmp++;
        if (md_start !== 1'b0 || md_busy !== 1'b1) begin
            n_bad++; $display("FAIL md_T2 start/busy got %b/%b want 0/1", md_start, md_busy);
        end
        instruct = W_ADD;
        #1; n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL md_T2 add in_ready got %b want 1", in_ready); end
        // T+3
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || alucontrol !== 4'b0010) begin
            n_bad++; $display("FAIL md_T3 add out got v=%b c=%b want 1/0010", out_valid, alucontrol);
        end
        $display("txn add      passed busy MD, alucontrol=%b", alucontrol);
        instruct = W_MFLO;
        #1; n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL md_T3 mflo in_ready got %b want 0", in_ready); end
        // T+4: last busy cycle
        @(negedge clk);
        n_cmp++;
        if (md_busy !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL md_T4 busy/out_valid got %b/%b want 1/0", md_busy, out_valid);
        end
        #1; n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL md_T4 mflo in_ready got %b want 0", in_ready); end
        // T+5: busy drops, mflo accepted
        @(negedge clk);
        n_cmp++;
        if (md_busy !== 1'b0) begin n_bad++; $display("FAIL md_T5 md_busy got %b want 0", md_busy); end
        #1; n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL md_T5 mflo in_ready got %b want 1", in_ready); end
        // T+6
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alucontrol !== 4'b0010 || md_start !== 1'b0) begin
            n_bad++; $display("FAIL md_T6 mflo out got v=%b c=%b s=%b want 1/0010/0",
                              out_valid, alucontrol, md_start);
        end
        $display("txn mflo     accepted after busy, alucontrol=%b", alucontrol);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; instruct = W_XOR; out_ready = 1'b0;
        #1; n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first in_ready got %b want 1", in_ready); end
        @(negedge clk);
        instruct = W_OR;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || alucontrol !== 4'b0011) begin
                n_bad++; $display("FAIL bp_hold%0d out got v=%b c=%b want 1/0011", i, out_valid, alucontrol);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d in_ready got %b want 0", i, in_ready); end
            $display("txn bp_hold%0d xor held, alucontrol=%b", i, alucontrol);
        end
        out_ready = 1'b1;
        #1; n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_resume in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alucontrol !== 4'b0001) begin
            n_bad++; $display("FAIL bp_or out got v=%b c=%b want 1/0001", out_valid, alucontrol);
        end
        $display("txn or       after backpressure, alucontrol=%b", alucontrol);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_nodup out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        in_valid = 1'b1; instruct = W_MULT; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (md_busy !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre busy/out_valid got %b/%b want 1/1", md_busy, out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (md_busy !== 1'b0 || md_start !== 1'b0) begin
            n_bad++; $display("FAIL rst_async md got busy=%b start=%b want 0/0", md_busy, md_start);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL rst_async out got v=%b c=%b i=%b want 0/0010/0",
                              out_valid, alucontrol, illegal);
        end
        $display("txn reset    mid-busy, md_busy=%b out_valid=%b", md_busy, out_valid);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (md_busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_after busy/out_valid got %b/%b want 0/0", md_busy, out_valid);
        end
        send_one(W_MULT, 4'b1111, 1'b0, "mult_rst");
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        instruct  = '0;
        out_ready = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_illegal();
        test_md_stall();
        test_backpressure();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
